// File: rtl/axi_rd_arbiter_pkg.sv
// axi_parameters: shared AXI widths, burst encoding and read-arbiter state type.
// Rev 1.0
`default_nettype none

package axi_parameters;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 8;

  parameter int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } B_TYPE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_rd_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker, first requester at or after ptr with wrap.
// Rev 1.0
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_valid
);

  localparam int IW = $clog2(NUM_REQ);

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NUM_REQ]) begin
        gnt_idx   = IW'((int'(ptr) + off) % NUM_REQ);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI4 read slave port, one burst in flight.
// Rev 1.0
`default_nettype none

module axi_rd_arbiter #(
  parameter int NUM_MASTERS = axi_parameters::NUM_MASTERS,
  parameter int ADDR_WIDTH  = axi_parameters::ADDR_WIDTH,
  parameter int DATA_WIDTH  = axi_parameters::DATA_WIDTH,
  parameter int ID_WIDTH    = axi_parameters::ID_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]          m_arlen,
  input  logic [NUM_MASTERS*3-1:0]          m_arsize,
  input  logic [NUM_MASTERS*2-1:0]          m_arburst,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_arid,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [1:0]                        m_rresp,
  output logic                              m_rlast,
  output logic [ID_WIDTH-1:0]               m_rid,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  output logic [7:0]                        s_arlen,
  output logic [2:0]                        s_arsize,
  output logic [1:0]                        s_arburst,
  output logic [ID_WIDTH-1:0]               s_arid,
  input  logic                              s_rvalid,
  output logic                              s_rready,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic [1:0]                        s_rresp,
  input  logic                              s_rlast,
  input  logic [ID_WIDTH-1:0]               s_rid,
  output logic [$clog2(NUM_MASTERS)-1:0]    grant_idx
);

  import axi_parameters::*;

  localparam int IW = $clog2(NUM_MASTERS);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          ar_hs;
  logic          r_last_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_MASTERS)
  ) u_rr (
    .req       (m_arvalid),
    .ptr       (rr_ptr_q),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  assign ar_hs     = s_arvalid && s_arready;
  assign r_last_hs = s_rvalid && s_rready && s_rlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) state_d = DATA;
      end
      DATA: begin
        // Pointer moves past the owner only when its burst has fully drained.
        if (r_last_hs) begin
          state_d  = IDLE;
          rr_ptr_d = IW'(rr_next(int'(grant_q), NUM_MASTERS));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    case (state_q)
      ADDR: begin
        s_arvalid          = 1'b1;
        m_arready[grant_q] = s_arready;
      end
      DATA: begin
        s_rready          = m_rready[grant_q];
        m_rvalid[grant_q] = s_rvalid;
      end
      default: ;
    endcase
  end

  assign s_araddr  = m_araddr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_arlen   = m_arlen[int'(grant_q)*8 +: 8];
  assign s_arsize  = m_arsize[int'(grant_q)*3 +: 3];
  assign s_arburst = m_arburst[int'(grant_q)*2 +: 2];
  assign s_arid    = m_arid[int'(grant_q)*ID_WIDTH +: ID_WIDTH];

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;
  assign m_rid   = s_rid;

  assign grant_idx = grant_q;

  // With a single burst in flight, R data outside DATA means the slave misbehaved.
  a_no_r_outside_data: assert property (@(posedge clk) disable iff (reset)
    !(s_rvalid && (state_q != DATA)));

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed self-checking bench for the two-master read arbiter.
// Rev 1.0
`default_nettype none

module tb_axi_rd_arbiter;

  import axi_parameters::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [63:0] m_araddr;
  logic [15:0] m_arlen;
  logic [5:0]  m_arsize;
  logic [3:0]  m_arburst;
  logic [15:0] m_arid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [7:0]  m_rid;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [7:0]  s_arid;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [7:0]  s_rid;
  logic [0:0]  grant_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.NUM_MASTERS(2)) dut (
    .clk(clk), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .grant_idx(grant_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [31:0] addr, input logic [7:0] len,
                         input logic [7:0] id);
    m_araddr[m*32 +: 32] = addr;
    m_arlen[m*8 +: 8]    = len;
    m_arsize[m*3 +: 3]   = 3'd2;
    m_arburst[m*2 +: 2]  = INCR;
    m_arid[m*8 +: 8]     = id;
    m_arvalid[m]         = 1'b1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic [7:0] id);
    s_rvalid = 1'b1;
    s_rdata  = d;
    s_rlast  = last;
    s_rid    = id;
    s_rresp  = 2'b00;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    m_arvalid = 2'b00;
    s_rvalid  = 1'b0;
    s_arready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1'b1;
    tick(); tick();
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL rst_s_arvalid: got %b exp 0", s_arvalid); end
    checks++; if (s_rready !== 1'b0) begin errors++; $display("FAIL rst_s_rready: got %b exp 0", s_rready); end
    checks++; if (m_arready !== 2'b00) begin errors++; $display("FAIL rst_m_arready: got %b exp 00", m_arready); end
    checks++; if (m_rvalid !== 2'b00) begin errors++; $display("FAIL rst_m_rvalid: got %b exp 00", m_rvalid); end
    checks++; if (grant_idx !== 1'b0) begin errors++; $display("FAIL rst_grant_idx: got %b exp 0", grant_idx); end
    m_arvalid = 2'b00; s_arready = 1'b0; reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    m_rready = 2'b11;
    set_req(0, 32'h1000, 8'd3, 8'h11);
    #1;
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL t1_no_comb_arvalid: got %b exp 0", s_arvalid); end
    tick();
    checks++;
    if (s_arvalid !== 1'b1 || s_araddr !== 32'h1000 || s_arlen !== 8'd3 || s_arburst !== 2'b01 ||
        s_arid !== 8'h11 || grant_idx !== 1'b0) begin
      errors++;
      $display("FAIL t1_ar_fields: got v=%b a=%h l=%0d b=%b id=%h g=%b exp v=1 a=1000 l=3 b=01 id=11 g=0",
               s_arvalid, s_araddr, s_arlen, s_arburst, s_arid, grant_idx);
    end
    s_arready = 1'b1; #1;
    checks++; if (m_arready !== 2'b01) begin errors++; $display("FAIL t1_m_arready: got %b exp 01", m_arready); end
    tick();
    m_arvalid[0] = 1'b0; s_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      beat(32'hD000_0000 + b, b == 3, 8'h11); #1;
      checks++;
      if (m_rvalid !== 2'b01 || m_rdata !== 32'hD000_0000 + b || m_rid !== 8'h11 ||
          m_rlast !== (b == 3) || s_rready !== 1'b1) begin
        errors++;
        $display("FAIL t1_beat%0d: got rv=%b d=%h id=%h last=%b srr=%b exp rv=01 d=%h id=11 last=%b srr=1",
                 b, m_rvalid, m_rdata, m_rid, m_rlast, s_rready, 32'hD000_0000 + b, b == 3);
      end
      tick();
    end
    checks++;
    if (s_rready !== 1'b0 || m_rvalid !== 2'b00 || s_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL t1_idle_after_last: got srr=%b rv=%b arv=%b exp 0 00 0", s_rready, m_rvalid, s_arvalid);
    end
    s_rvalid = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_rready = 2'b11;
    set_req(0, 32'h2000, 8'd1, 8'hA0);
    set_req(1, 32'h3000, 8'd1, 8'hB1);
    tick();
    checks++;
    if (grant_idx !== 1'b0 || s_araddr !== 32'h2000 || s_arid !== 8'hA0) begin
      errors++;
      $display("FAIL t2_first_grant: got g=%b a=%h id=%h exp g=0 a=2000 id=a0", grant_idx, s_araddr, s_arid);
    end
    s_arready = 1'b1; #1;
    checks++; if (m_arready !== 2'b01) begin errors++; $display("FAIL t2_m_arready0: got %b exp 01", m_arready); end
    tick();
    m_arvalid[0] = 1'b0; s_arready = 1'b0; #1;
    checks++; if (m_arready !== 2'b00) begin errors++; $display("FAIL t2_arready_in_data: got %b exp 00", m_arready); end
    for (int b = 0; b < 2; b++) begin
      beat(32'hA000 + b, b == 1, 8'hA0); #1;
      checks++; if (m_rvalid !== 2'b01) begin errors++; $display("FAIL t2_m0_rvalid%0d: got %b exp 01", b, m_rvalid); end
      tick();
    end
    s_rvalid = 1'b0; #1;
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("FAIL t2_idle_gap: got %b exp 0", s_arvalid); end
    tick();
    checks++;
    if (s_arvalid !== 1'b1 || grant_idx !== 1'b1 || s_araddr !== 32'h3000 || s_arid !== 8'hB1) begin
      errors++;
      $display("FAIL t2_second_grant: got v=%b g=%b a=%h id=%h exp v=1 g=1 a=3000 id=b1",
               s_arvalid, grant_idx, s_araddr, s_arid);
    end
    s_arready = 1'b1; #1;
    checks++; if (m_arready !== 2'b10) begin errors++; $display("FAIL t2_m_arready1: got %b exp 10", m_arready); end
    tick();
    m_arvalid[1] = 1'b0; s_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      beat(32'hB000 + b, b == 1, 8'hB1); #1;
      checks++;
      if (m_rvalid !== 2'b10 || m_rid !== 8'hB1) begin
        errors++; $display("FAIL t2_m1_beat%0d: got rv=%b id=%h exp rv=10 id=b1", b, m_rvalid, m_rid);
      end
      tick();
    end
    s_rvalid = 1'b0;
  endtask

  task automatic test_fairness();
    logic [7:0] id_m [2];
    logic [7:0] eid;
    int         w;
    id_m[0] = 8'h40; id_m[1] = 8'h80;
    m_rready = 2'b11;
    set_req(0, 32'h5000, 8'd1, id_m[0]);
    set_req(1, 32'h6000, 8'd1, id_m[1]);
    for (int b = 0; b < 6; b++) begin
      w = 0;
      while (s_arvalid !== 1'b1 && w < 8) begin tick(); w++; end
      checks++; if (w >= 8) begin errors++; $display("FAIL t4_grant_timeout: waited %0d cycles, limit 8", w); end
      eid = id_m[b % 2];
      checks++;
      if (grant_idx !== 1'(b % 2) || s_arid !== eid) begin
        errors++;
        $display("FAIL t4_burst%0d_grant: got g=%b id=%h exp g=%0d id=%h", b, grant_idx, s_arid, b % 2, eid);
      end
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0;
      id_m[b % 2] = id_m[b % 2] + 8'd1;
      set_req(b % 2, (b % 2 == 0) ? 32'h5000 : 32'h6000, 8'd1, id_m[b % 2]);
      for (int k = 0; k < 2; k++) begin
        beat(32'hF000 + b * 2 + k, k == 1, eid); #1;
        checks++;
        if (m_rid !== eid || m_rvalid !== ((b % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL t4_burst%0d_beat%0d: got id=%h rv=%b exp id=%h", b, k, m_rid, m_rvalid, eid);
        end
        tick();
      end
      s_rvalid = 1'b0;
    end
    m_arvalid = 2'b00;
  endtask

  task automatic test_single_beat();
    m_rready = 2'b11;
    set_req(1, 32'h8000, 8'd0, 8'h55);
    tick();
    checks++;
    if (grant_idx !== 1'b1 || s_arlen !== 8'd0) begin
      errors++; $display("FAIL t5_grant: got g=%b len=%0d exp g=1 len=0", grant_idx, s_arlen);
    end
    s_arready = 1'b1;
    tick();
    m_arvalid[1] = 1'b0; s_arready = 1'b0;
    beat(32'h5A5A_5A5A, 1'b1, 8'h55); s_rresp = 2'b10; #1;
    checks++;
    if (m_rvalid !== 2'b10 || m_rlast !== 1'b1 || m_rresp !== 2'b10 || m_rdata !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL t5_beat: got rv=%b last=%b resp=%b d=%h exp 10 1 10 5a5a5a5a", m_rvalid, m_rlast, m_rresp, m_rdata);
    end
    tick();
    #1;
    checks++;
    if (s_rready !== 1'b0 || m_rvalid !== 2'b00) begin
      errors++; $display("FAIL t5_exit: got srr=%b rv=%b exp 0 00", s_rready, m_rvalid);
    end
    s_rvalid = 1'b0;
    set_req(0, 32'h9000, 8'd0, 8'h66);
    tick();
    checks++;
    if (s_arvalid !== 1'b1 || grant_idx !== 1'b0 || s_araddr !== 32'h9000) begin
      errors++; $display("FAIL t5_next_grant: got v=%b g=%b a=%h exp 1 0 9000", s_arvalid, grant_idx, s_araddr);
    end
    s_arready = 1'b1;
    tick();
    m_arvalid[0] = 1'b0; s_arready = 1'b0;
    beat(32'h6666, 1'b1, 8'h66); #1;
    checks++; if (m_rvalid !== 2'b01) begin errors++; $display("FAIL t5_next_beat: got %b exp 01", m_rvalid); end
    tick();
    s_rvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] got [$];
    logic        rr;
    int          k;
    int          cyc;
    m_rready = 2'b00; s_arready = 1'b0;
    set_req(0, 32'h4000, 8'd3, 8'h33);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_arvalid !== 1'b1 || s_araddr !== 32'h4000 || s_arlen !== 8'd3 || s_arid !== 8'h33 || m_arready !== 2'b00) begin
        errors++;
        $display("FAIL t3_ar_stall%0d: got v=%b a=%h l=%0d id=%h mar=%b exp 1 4000 3 33 00",
                 i, s_arvalid, s_araddr, s_arlen, s_arid, m_arready);
      end
      tick();
    end
    s_arready = 1'b1;
    tick();
    m_arvalid[0] = 1'b0; s_arready = 1'b0;
    k = 0; cyc = 0; rr = 1'b0;
    while (k < 4 && cyc < 20) begin
      m_rready[0] = rr;
      beat(32'hB000 + k, k == 3, 8'h33); #1;
      checks++; if (s_rready !== rr) begin errors++; $display("FAIL t3_rready_mirror%0d: got %b exp %b", cyc, s_rready, rr); end
      if (rr) got.push_back(m_rdata);
      tick();
      if (rr) k++;
      rr = ~rr;
      cyc++;
    end
    s_rvalid = 1'b0;
    checks++; if (k < 4) begin errors++; $display("FAIL t3_timeout: beats %0d exp 4", k); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL t3_beat_count: got %0d exp 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] !== 32'hB000 + i) begin errors++; $display("FAIL t3_sb%0d: got %h exp %h", i, got[i], 32'hB000 + i); end
    end
  endtask

  task automatic test_reset_mid_burst();
    m_rready = 2'b11;
    set_req(0, 32'h7000, 8'd7, 8'h77);
    tick();
    s_arready = 1'b1;
    tick();
    m_arvalid[0] = 1'b0; s_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      beat(32'hE000 + b, 1'b0, 8'h77);
      tick();
    end
    beat(32'hE002, 1'b0, 8'h77); #1;
    checks++; if (m_rvalid !== 2'b01) begin errors++; $display("FAIL t6_in_data: got %b exp 01", m_rvalid); end
    reset = 1'b1; #1;
    checks++;
    if (s_arvalid !== 1'b0 || s_rready !== 1'b0 || m_rvalid !== 2'b00 || m_arready !== 2'b00 || grant_idx !== 1'b0) begin
      errors++;
      $display("FAIL t6_async_reset: got arv=%b srr=%b rv=%b mar=%b g=%b exp 0 0 00 00 0",
               s_arvalid, s_rready, m_rvalid, m_arready, grant_idx);
    end
    s_rvalid = 1'b0;
    tick(); tick();
    set_req(0, 32'hC000, 8'd0, 8'hC0);
    set_req(1, 32'hD000, 8'd0, 8'hD1);
    reset = 1'b0;
    tick();
    checks++;
    if (s_arvalid !== 1'b1 || grant_idx !== 1'b0 || s_araddr !== 32'hC000) begin
      errors++; $display("FAIL t6_fresh_grant: got v=%b g=%b a=%h exp 1 0 c000", s_arvalid, grant_idx, s_araddr);
    end
    m_arvalid = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0; m_arid = '0;
    m_rready = '0; s_arready = 1'b0;
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rid = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_single_beat();
    test_backpressure();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

`default_nettype wire
